// File: rtl/boxhead_gfx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : boxhead_gfx_pkg                                          |
// | Brief  : Shared constants and blit FSM state type                 |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
package boxhead_gfx_pkg;
  localparam int BLIT_ADDR_W  = 20;
  localparam int BLIT_DIM_W   = 7;
  localparam int BLIT_COORD_W = 11;
  localparam int FB_X_W       = 10;
  localparam int FB_Y_W       = 9;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam logic [3:0] TRANSPARENT = 4'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } blit_state_e;
endpackage
`default_nettype wire

// File: rtl/blit_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : blit_addr_gen                                            |
// | Brief  : Sprite pixel address sequencer (col/row walk, h-flip)    |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module blit_addr_gen
  import boxhead_gfx_pkg::*;
#(
  parameter int ADDR_W = BLIT_ADDR_W,
  parameter int DIM_W  = BLIT_DIM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic              flip_h,
  output logic [ADDR_W-1:0] read_addr,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic              last
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DIM_W-1:0]  DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};

  logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
  logic              flip_q, flip_d;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [ADDR_W-1:0] w_ext, in_w_ext;

  assign w_ext     = {{(ADDR_W-DIM_W){1'b0}}, width_q};
  assign in_w_ext  = {{(ADDR_W-DIM_W){1'b0}}, width};
  assign last      = (col_q == width_q - DIM_ONE) && (row_q == height_q - DIM_ONE);
  assign read_addr = addr_q;
  assign col       = col_q;
  assign row       = row_q;

  // Next address: counters track the pixel whose address is currently on read_addr
  always_comb begin
    width_d    = width_q;
    height_d   = height_q;
    flip_d     = flip_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (load) begin
      width_d    = width;
      height_d   = height;
      flip_d     = flip_h;
      col_d      = '0;
      row_d      = '0;
      row_base_d = src_base;
      addr_d     = flip_h ? (src_base + in_w_ext - ADDR_ONE) : src_base;
    end else if (advance && !last) begin
      if (col_q == width_q - DIM_ONE) begin
        col_d      = '0;
        row_d      = row_q + DIM_ONE;
        row_base_d = row_base_q + w_ext;
        // mirrored rows start at the rightmost pixel of the next row
        addr_d     = flip_q ? (row_base_q + w_ext + w_ext - ADDR_ONE) : (addr_q + ADDR_ONE);
      end else begin
        col_d  = col_q + DIM_ONE;
        addr_d = flip_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
      end
    end
  end

  // Counter and address registers
  always_ff @(posedge clk) begin
    if (reset) begin
      width_q    <= '0;
      height_q   <= '0;
      flip_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      width_q    <= width_d;
      height_q   <= height_d;
      flip_q     <= flip_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : sprite_blitter                                           |
// | Brief  : Sprite-to-framebuffer blitter with clipping/transparency |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module sprite_blitter
  import boxhead_gfx_pkg::*;
#(
  parameter int ADDR_W  = BLIT_ADDR_W,
  parameter int DIM_W   = BLIT_DIM_W,
  parameter int COORD_W = BLIT_COORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [COORD_W-1:0] dst_x,
  input  logic [COORD_W-1:0] dst_y,
  input  logic              flip_h,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [3:0]        pix_data,
  output logic              fb_we,
  output logic [FB_X_W-1:0] fb_x,
  output logic [FB_Y_W-1:0] fb_y,
  output logic [3:0]        fb_data,
  output logic              busy,
  output logic              done
);
  localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H);

  blit_state_e        state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [COORD_W-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic               s0_valid_q, s0_valid_d;
  logic               s1_valid_q, s1_valid_d, s1_inb_q, s1_inb_d;
  logic [FB_X_W-1:0]  s1_x_q, s1_x_d, fb_x_q, fb_x_d;
  logic [FB_Y_W-1:0]  s1_y_q, s1_y_d, fb_y_q, fb_y_d;
  logic               fb_we_q, fb_we_d;
  logic [3:0]         fb_data_q, fb_data_d;
  logic               load, advance, last;
  logic [DIM_W-1:0]   col, row;
  logic [COORD_W:0]   x_s0, y_s0;
  logic               in_b;

  blit_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .advance  (advance),
    .src_base (src_base),
    .width    (width),
    .height   (height),
    .flip_h   (flip_h),
    .read_addr(read_addr),
    .col      (col),
    .row      (row),
    .last     (last)
  );

  // Stage-0 destination of the pixel on read_addr, widened by one bit so negatives stay visible
  assign x_s0 = {dst_x_q[COORD_W-1], dst_x_q} + {{(COORD_W+1-DIM_W){1'b0}}, col};
  assign y_s0 = {dst_y_q[COORD_W-1], dst_y_q} + {{(COORD_W+1-DIM_W){1'b0}}, row};
  assign in_b = !x_s0[COORD_W] && (x_s0 < X_LIM) && !y_s0[COORD_W] && (y_s0 < Y_LIM);

  // FSM sequencing and the two-stage pixel pipeline matching the memory latency
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dst_x_d    = dst_x_q;
    dst_y_d    = dst_y_q;
    s0_valid_d = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          dst_x_d = dst_x;
          dst_y_d = dst_y;
          if (width == '0 || height == '0) begin
            state_d = FINISH;
          end else begin
            load       = 1'b1;
            s0_valid_d = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        if (last) begin
          state_d = DRAIN;
        end else begin
          advance    = 1'b1;
          s0_valid_d = 1'b1;
        end
      end
      // together with FINISH this gives the two cycles the last pixel needs to reach fb_*
      DRAIN:   state_d = FINISH;
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    s1_valid_d = s0_valid_q;
    s1_inb_d   = in_b;
    s1_x_d     = x_s0[FB_X_W-1:0];
    s1_y_d     = y_s0[FB_Y_W-1:0];
    fb_we_d    = s1_valid_q && s1_inb_q && (pix_data != TRANSPARENT);
    fb_x_d     = s1_x_q;
    fb_y_d     = s1_y_q;
    fb_data_d  = pix_data;
  end

  // All control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_inb_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      fb_we_q    <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dst_x_q    <= dst_x_d;
      dst_y_q    <= dst_y_d;
      s0_valid_q <= s0_valid_d;
      s1_valid_q <= s1_valid_d;
      s1_inb_q   <= s1_inb_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      fb_we_q    <= fb_we_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      fb_data_q  <= fb_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign fb_we   = fb_we_q;
  assign fb_x    = fb_x_q;
  assign fb_y    = fb_y_q;
  assign fb_data = fb_data_q;
endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_sprite_blitter                                        |
// | Brief  : Directed self-checking bench for sprite_blitter          |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module tb_sprite_blitter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [19:0] src_base = '0;
  logic [6:0]  width = '0;
  logic [6:0]  height = '0;
  logic [10:0] dst_x = '0;
  logic [10:0] dst_y = '0;
  logic        flip_h = 1'b0;
  logic [19:0] read_addr;
  logic [3:0]  pix_data = '0;
  logic        fb_we;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [3:0]  fb_data;
  logic        busy;
  logic        done;

  logic [3:0]  mem [0:1023];
  int checks = 0;
  int failures = 0;

  sprite_blitter dut (
    .clk(clk), .reset(reset), .start(start), .src_base(src_base),
    .width(width), .height(height), .dst_x(dst_x), .dst_y(dst_y),
    .flip_h(flip_h), .read_addr(read_addr), .pix_data(pix_data),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sprite memory with one cycle of read latency
  always @(posedge clk) pix_data <= mem[read_addr[9:0]];

  // Present a command and return 1 time unit after the accepting edge (edge 0)
  task automatic issue(input logic [19:0] b, input logic [6:0] w, input logic [6:0] h,
                       input logic [10:0] x, input logic [10:0] y, input logic f);
    src_base = b; width = w; height = h; dst_x = x; dst_y = y; flip_h = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({read_addr, fb_we, fb_x, fb_y, fb_data, busy, done} !== 47'd0) begin
      failures++;
      $display("FAIL reset_state: got addr=%0h we=%0b x=%0d y=%0d d=%0h busy=%0b done=%0b, expected all zero",
               read_addr, fb_we, fb_x, fb_y, fb_data, busy, done);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // 2x2 sprite at (10,20) from 0x100 holding 1,2,3,4; flip mirrors each row
  task automatic test_blit_2x2(input logic f);
    logic [19:0] ea [4];
    logic [9:0]  ex [4];
    logic [8:0]  ey [4];
    logic [3:0]  ed [4];
    logic        ok;
    mem[10'h100] = 4'd1; mem[10'h101] = 4'd2; mem[10'h102] = 4'd3; mem[10'h103] = 4'd4;
    ex[0] = 10'd10; ex[1] = 10'd11; ex[2] = 10'd10; ex[3] = 10'd11;
    ey[0] = 9'd20;  ey[1] = 9'd20;  ey[2] = 9'd21;  ey[3] = 9'd21;
    if (!f) begin
      ea[0] = 20'h100; ea[1] = 20'h101; ea[2] = 20'h102; ea[3] = 20'h103;
      ed[0] = 4'd1; ed[1] = 4'd2; ed[2] = 4'd3; ed[3] = 4'd4;
    end else begin
      ea[0] = 20'h101; ea[1] = 20'h100; ea[2] = 20'h103; ea[3] = 20'h102;
      ed[0] = 4'd2; ed[1] = 4'd1; ed[2] = 4'd4; ed[3] = 4'd3;
    end
    issue(20'h100, 7'd2, 7'd2, 11'd10, 11'd20, f);
    checks++;
    if (read_addr !== ea[0] || busy !== 1'b1) begin
      failures++;
      $display("FAIL blit2x2_f%0b_edge0: got addr=%0h busy=%0b expected addr=%0h busy=1", f, read_addr, busy, ea[0]);
    end
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e <= 3) begin
        checks++;
        if (read_addr !== ea[e]) begin
          failures++;
          $display("FAIL blit2x2_f%0b_addr e%0d: got %0h expected %0h", f, e, read_addr, ea[e]);
        end
      end
      checks++;
      if (e >= 2 && e <= 5)
        ok = (fb_we === 1'b1) && (fb_x === ex[e-2]) && (fb_y === ey[e-2]) && (fb_data === ed[e-2]);
      else
        ok = (fb_we === 1'b0);
      if (!ok) begin
        failures++;
        if (e >= 2 && e <= 5)
          $display("FAIL blit2x2_f%0b_write e%0d: got we=%0b (%0d,%0d,%0h) expected we=1 (%0d,%0d,%0h)",
                   f, e, fb_we, fb_x, fb_y, fb_data, ex[e-2], ey[e-2], ed[e-2]);
        else
          $display("FAIL blit2x2_f%0b_write e%0d: got we=%0b expected we=0", f, e, fb_we);
      end
      checks++;
      if (done !== (e == 6) || busy !== (e < 6)) begin
        failures++;
        $display("FAIL blit2x2_f%0b_done e%0d: got done=%0b busy=%0b expected done=%0b busy=%0b",
                 f, e, done, busy, (e == 6), (e < 6));
      end
    end
  endtask

  // 3x1 at (-1,479) with data 5,0,7: only (1,479,7) survives
  task automatic test_clip_left();
    mem[10'h200] = 4'd5; mem[10'h201] = 4'd0; mem[10'h202] = 4'd7;
    issue(20'h200, 7'd3, 7'd1, 11'h7FF, 11'd479, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      checks++;
      if (e == 4) begin
        if (fb_we !== 1'b1 || fb_x !== 10'd1 || fb_y !== 9'd479 || fb_data !== 4'd7) begin
          failures++;
          $display("FAIL clip_left_write e%0d: got we=%0b (%0d,%0d,%0h) expected we=1 (1,479,7)",
                   e, fb_we, fb_x, fb_y, fb_data);
        end
      end else if (fb_we !== 1'b0) begin
        failures++;
        $display("FAIL clip_left_write e%0d: got we=%0b expected we=0", e, fb_we);
      end
      checks++;
      if (done !== (e == 5)) begin
        failures++;
        $display("FAIL clip_left_done e%0d: got %0b expected %0b", e, done, (e == 5));
      end
    end
  endtask

  // 2x2 at (639,479): only the top-left pixel is on screen
  task automatic test_clip_right();
    mem[10'h300] = 4'd1; mem[10'h301] = 4'd2; mem[10'h302] = 4'd3; mem[10'h303] = 4'd4;
    issue(20'h300, 7'd2, 7'd2, 11'd639, 11'd479, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      checks++;
      if (e == 2) begin
        if (fb_we !== 1'b1 || fb_x !== 10'd639 || fb_y !== 9'd479 || fb_data !== 4'd1) begin
          failures++;
          $display("FAIL clip_right_write e%0d: got we=%0b (%0d,%0d,%0h) expected we=1 (639,479,1)",
                   e, fb_we, fb_x, fb_y, fb_data);
        end
      end else if (fb_we !== 1'b0) begin
        failures++;
        $display("FAIL clip_right_write e%0d: got we=%0b expected we=0", e, fb_we);
      end
      checks++;
      if (done !== (e == 6)) begin
        failures++;
        $display("FAIL clip_right_done e%0d: got %0b expected %0b", e, done, (e == 6));
      end
    end
  endtask

  task automatic test_zero_width();
    issue(20'h100, 7'd0, 7'd3, 11'd5, 11'd5, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || fb_we !== 1'b0) begin
      failures++;
      $display("FAIL zero_w_edge0: got busy=%0b done=%0b we=%0b expected 1,0,0", busy, done, fb_we);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || fb_we !== 1'b0) begin
      failures++;
      $display("FAIL zero_w_edge1: got busy=%0b done=%0b we=%0b expected 0,1,0", busy, done, fb_we);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || fb_we !== 1'b0) begin
      failures++;
      $display("FAIL zero_w_edge2: got done=%0b we=%0b expected 0,0", done, fb_we);
    end
  endtask

  task automatic test_back_to_back();
    mem[10'h200] = 4'd9;
    issue(20'h100, 7'd2, 7'd1, 11'd0, 11'd0, 1'b0);
    @(posedge clk); #1;                          // after edge 1
    src_base = 20'h3F0; start = 1'b1;            // must be ignored
    @(posedge clk); #1;                          // after edge 2
    start = 1'b0;
    checks++;
    if (read_addr !== 20'h101 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ignore: got addr=%0h busy=%0b expected addr=101 busy=1", read_addr, busy);
    end
    @(posedge clk); #1;                          // after edge 3
    @(posedge clk); #1;                          // after edge 4: done cycle
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done1: got done=%0b busy=%0b expected 1,0", done, busy);
    end
    src_base = 20'h200; width = 7'd1; height = 7'd1; dst_x = 11'd3; dst_y = 11'd4;
    start = 1'b1;
    @(posedge clk); #1;                          // after edge 5: new blit edge 0
    start = 1'b0;
    checks++;
    if (read_addr !== 20'h200 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: got addr=%0h busy=%0b done=%0b expected 200,1,0", read_addr, busy, done);
    end
    @(posedge clk); #1;                          // after edge 6
    @(posedge clk); #1;                          // after edge 7
    checks++;
    if (fb_we !== 1'b1 || fb_x !== 10'd3 || fb_y !== 9'd4 || fb_data !== 4'd9) begin
      failures++;
      $display("FAIL b2b_write: got we=%0b (%0d,%0d,%0h) expected we=1 (3,4,9)", fb_we, fb_x, fb_y, fb_data);
    end
    @(posedge clk); #1;                          // after edge 8
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done2: got done=%0b expected 1", done);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) mem[i] = 4'(i + 1);
    issue(20'h000, 7'd4, 7'd4, 11'd100, 11'd100, 1'b0);
    repeat (3) @(posedge clk);
    #1;                                          // after edge 3
    reset = 1'b1;
    @(posedge clk); #1;                          // after edge 4
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || fb_we !== 1'b0 || done !== 1'b0 || read_addr !== 20'h0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%0b we=%0b done=%0b addr=%0h expected 0,0,0,0",
               busy, fb_we, done, read_addr);
    end
    for (int e = 0; e < 25; e++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || fb_we !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet c%0d: got done=%0b we=%0b busy=%0b expected 0,0,0", e, done, fb_we, busy);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
    test_reset();
    test_blit_2x2(1'b0);
    test_blit_2x2(1'b1);
    test_clip_left();
    test_clip_right();
    test_zero_width();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
